lap_fifo_apb: RTL and testbench
===============================

# lap_fifo_apb

Ten-entry lap-time buffer with an APB slave register interface. It sits directly downstream of the stopwatch core, capturing every 26-bit lap record together with its lap index, and lets the CPU read laps in arrival order or by index. It owns its own read/write pointers and tracks count, full, empty and overflow status.

## Interface
- DEPTH, 10, number of lap entries (2..15)
- ADDR_W, 8, APB address width
- iPCLK  in  1  system clock; all logic on rising edge
- iRESETn  in  1  reset, synchronous, active-low
- lap_wr  in  1  one-cycle strobe; lap/lap_addr valid this cycle (stopwatch lap_store delayed one cycle)
- lap  in  26  {hour[6:0], min[5:0], sec[5:0], sub_sec[6:0]}
- lap_addr  in  4  stopwatch lap index accompanying lap
- iPSEL  in  1  APB select
- iPENABLE  in  1  APB enable
- iPWRITE  in  1  APB write=1 / read=0
- iPADDR  in  ADDR_W  byte address, bits [1:0] ignored
- iPWDATA  in  32  write data
- oPRDATA  out  32  read data, registered
- oPREADY  out  1  transfer complete, registered
- oIRQ  out  1  level interrupt (only with LAP_IRQ_EN)

## Operation
- Entry word: {lap_addr[3:0], 2'b00, lap[25:0]}.
- Circular FIFO: wr_ptr, rd_ptr in 0..DEPTH-1, wrap DEPTH-1 -> 0; count 0..DEPTH.
- lap_wr, not full: write slot wr_ptr, wr_ptr++, count++.
- lap_wr, full: overwrite oldest slot, wr_ptr++, rd_ptr++, count stays DEPTH, OVF flag set (sticky).
- Register map:
  - 0x00 STATUS (RO): [3:0] count, [4] empty, [5] full, [6] OVF, [7] IRQ_EN.
  - 0x04 CTRL (W): bit0 CLEAR (pointers, count -> 0; OVF cleared), bit1 OVF_CLR, bit2 IRQ_EN (stored; reads back via STATUS). Reads 0.
  - 0x08 POP (RO): returns oldest entry and removes it (rd_ptr++, count--); when empty returns 0, no state change.
  - 0x40 + 4*i, i < DEPTH (RO): entry at logical index i (0 = oldest), no pop; i >= count returns 0.
  - Other addresses: reads 0, writes ignored; no PSLVERR.
- Simultaneous events, same cycle:
  - POP and lap_wr when not full: both act, count unchanged.
  - POP and lap_wr when full: pop then write, no overflow.
  - POP and lap_wr when empty: POP returns 0, write lands, count = 1.
  - CLEAR and lap_wr: CLEAR wins, write dropped.
  - OVF_CLR and a new overflow: OVF stays set.
- Reset: pointers, count, OVF, IRQ_EN, oPRDATA, oPREADY all 0; storage contents not reset (unreadable until written).

## Timing
- APB setup phase: iPSEL=1, iPENABLE=0. Access phase: iPENABLE=1.
- Every transfer has exactly one wait state:
  - first access cycle oPREADY=0;
  - second access cycle oPREADY=1;
  - oPREADY returns to 0 the following cycle.
- Read data is sampled at the end of the first access cycle into oPRDATA and held stable while oPREADY=1; otherwise oPRDATA=0.
- Side effects (POP, CTRL writes) take effect on the clock edge ending the oPREADY=1 cycle. Status reads reflect state before that edge.
- lap_wr latency: an entry written at edge N is visible to a read whose data is sampled at edge N+1 or later.
- iRESETn low mid-transfer: oPREADY=0 next cycle; the transfer is abandoned with no side effect.

## Configuration
- LAP_IRQ_EN defined: oIRQ port exists; oIRQ = IRQ_EN & (~empty | OVF), registered, reset 0.
- LAP_IRQ_EN undefined: no oIRQ port; CTRL bit2 ignored; STATUS[7] reads 0.

## Test plan
- Reset, read 0x00 -> 0x0000_0010 (empty=1); oPREADY high exactly on second access cycle.
- 3 lap_wr (lap=0x0000064, 0x00000C8, 0x000012C; lap_addr=1,2,3); read 0x00 -> count=3; read 0x44 -> 0x2000_00C8; read 0x08 three times -> 0x1000_0064, 0x2000_00C8, 0x3000_012C; then STATUS empty=1.
- 11 lap_wr with lap=1..11 -> STATUS full=1, OVF=1, count=10; POP -> lap 2; write CTRL=0x2 -> OVF=0.
- Full FIFO, lap_wr in the same cycle as the POP side-effect edge -> count stays 10, OVF stays 0.
- CTRL=0x1 coincident with lap_wr -> count=0, and next POP returns 0.
- LAP_IRQ_EN: CTRL=0x4, one lap_wr -> oIRQ=1 within 2 cycles; POP it -> oIRQ=0.

Source files
------------

// File: rtl/lap_fifo_apb.sv
// -----------------------------------------------------------------------------
// lap_fifo_apb
//   Lap-time buffer with an APB slave register interface. It captures every
//   lap record from the stopwatch core together with its lap index in a
//   circular buffer. Software reads the laps oldest-first (POP) or by logical
//   index. Pointers, count, full, empty and a sticky overflow flag are kept
//   locally. When a lap arrives while the buffer is full, the oldest entry is
//   overwritten.
//
//   Entry word: {lap_addr[3:0], 2'b00, lap[25:0]}
//
//   Register map (byte addresses, bits [1:0] ignored):
//     0x00 STATUS (RO): [3:0] count, [4] empty, [5] full, [6] OVF, [7] IRQ_EN
//     0x04 CTRL   (W) : bit0 CLEAR, bit1 OVF_CLR, bit2 IRQ_EN; reads 0
//     0x08 POP    (RO): oldest entry, removed on completion; 0 when empty
//     0x40+4*i    (RO): entry at logical index i (0 = oldest); 0 if i >= count
//
//   Every APB transfer has exactly one wait state. Read data is captured at
//   the end of the first access cycle and held while oPREADY is high. Side
//   effects commit on the edge that ends the oPREADY cycle.
//
//   Optional feature: define LAP_IRQ_EN to add the oIRQ level interrupt,
//   oIRQ = IRQ_EN & (~empty | OVF), registered.
//
// Ports:
//   iPCLK     in   system clock, rising edge
//   iRESETn   in   synchronous active-low reset
//   lap_wr    in   one-cycle strobe, lap/lap_addr valid
//   lap       in   26-bit lap record {hour, min, sec, sub_sec}
//   lap_addr  in   4-bit stopwatch lap index
//   iPSEL, iPENABLE, iPWRITE, iPADDR, iPWDATA   APB request
//   oPRDATA   out  registered read data
//   oPREADY   out  registered transfer-complete
//   oIRQ      out  level interrupt (LAP_IRQ_EN builds only)
// -----------------------------------------------------------------------------
module lap_fifo_apb #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 8
) (
  input  logic              iPCLK,
  input  logic              iRESETn,
  input  logic              lap_wr,
  input  logic [25:0]       lap,
  input  logic [3:0]        lap_addr,
  input  logic              iPSEL,
  input  logic              iPENABLE,
  input  logic              iPWRITE,
  input  logic [ADDR_W-1:0] iPADDR,
  input  logic [31:0]       iPWDATA,
  output logic [31:0]       oPRDATA,
  output logic              oPREADY
`ifdef LAP_IRQ_EN
  ,
  output logic              oIRQ
`endif
);

  localparam int WORD_W = ADDR_W - 2;

  localparam logic [WORD_W-1:0] WA_STATUS   = WORD_W'(0);
  localparam logic [WORD_W-1:0] WA_CTRL     = WORD_W'(1);
  localparam logic [WORD_W-1:0] WA_POP      = WORD_W'(2);
  localparam logic [WORD_W-1:0] WA_IDX_BASE = WORD_W'(16);

  localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
  localparam logic [3:0] LAST_PTR = 4'(DEPTH - 1);

  typedef enum logic {
    APB_IDLE,  // waiting for an access phase
    APB_DONE   // wait state served; oPREADY high, side effects commit at edge
  } apb_state_t;

  apb_state_t state, state_next;

  // Storage and bookkeeping
  logic [31:0] mem [DEPTH];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [3:0]  count;
  logic        ovf;
  logic        irq_en;
  logic        pop_ok;  // FIFO held data when the POP read was sampled

  logic full;
  logic empty;
  assign full  = (count == DEPTH_C);
  assign empty = (count == 4'd0);

  // APB decode
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] idx_off;
  logic              in_idx;
  logic [4:0]        slot_sum;
  logic [3:0]        slot;
  logic              apb_access;
  logic              sample;
  logic              commit;

  assign word       = iPADDR[ADDR_W-1:2];
  assign idx_off    = word - WA_IDX_BASE;
  assign in_idx     = (word >= WA_IDX_BASE) && (idx_off < WORD_W'(count));
  // Logical index -> physical slot; rd_ptr + i stays below 2*DEPTH, so one
  // conditional subtract is enough for the wrap.
  assign slot_sum   = {1'b0, rd_ptr} + {1'b0, idx_off[3:0]};
  assign slot       = (slot_sum >= 5'(DEPTH)) ? 4'(slot_sum - 5'(DEPTH)) : slot_sum[3:0];
  assign apb_access = iPSEL & iPENABLE;
  assign sample     = (state == APB_IDLE) & apb_access;
  assign commit     = (state == APB_DONE) & apb_access;

  assign oPREADY = (state == APB_DONE);

  // Write data bits that carry no function, and the byte-lane address bits.
  logic unused_bits;
  assign unused_bits = ^{iPWDATA, iPADDR[1:0]};

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == LAST_PTR) ? 4'd0 : p + 4'd1;
  endfunction

  // Next-state and command decode
  logic        do_clear;
  logic        do_ovf_clr;
  logic        do_pop;
  logic        wr_en;
  logic        overflow;
  logic [31:0] rdata;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    do_clear   = 1'b0;
    do_ovf_clr = 1'b0;
    do_pop     = 1'b0;
    rdata      = '0;

    unique case (state)
      APB_IDLE: if (apb_access) state_next = APB_DONE;
      APB_DONE: state_next = APB_IDLE;
      default:  state_next = APB_IDLE;
    endcase

    if (commit) begin
      if (iPWRITE && word == WA_CTRL) begin
        do_clear   = iPWDATA[0];
        do_ovf_clr = iPWDATA[1];
      end
      if (!iPWRITE && word == WA_POP) do_pop = pop_ok;
    end

    if (!iPWRITE) begin
      if (word == WA_STATUS) begin
        rdata = {24'h0, irq_en, ovf, full, empty, count};
      end else if (word == WA_POP) begin
        if (!empty) rdata = mem[rd_ptr];
      end else if (in_idx) begin
        rdata = mem[slot];
      end
    end
  end

  // CLEAR beats a coincident lap; a POP on the same edge frees the slot the
  // incoming lap needs, so that case is not an overflow.
  assign wr_en    = lap_wr & ~do_clear;
  assign overflow = wr_en & full & ~do_pop;

  always_ff @(posedge iPCLK) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others, matching real hardware.
    if (!iRESETn) begin
      state   <= APB_IDLE;
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      count   <= 4'd0;
      ovf     <= 1'b0;
      pop_ok  <= 1'b0;
      oPRDATA <= '0;
    end else begin
      state   <= state_next;
      oPRDATA <= sample ? rdata : 32'h0;
      if (sample) pop_ok <= ~empty;

      if (do_clear) begin
        wr_ptr <= 4'd0;
        rd_ptr <= 4'd0;
        count  <= 4'd0;
        ovf    <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
        if (do_pop || overflow) rd_ptr <= ptr_inc(rd_ptr);

        unique case ({wr_en, do_pop})
          2'b10:   if (!full) count <= count + 4'd1;
          2'b01:   count <= count - 4'd1;
          default: ;
        endcase

        // A new overflow wins over a same-edge OVF_CLR.
        if (overflow)        ovf <= 1'b1;
        else if (do_ovf_clr) ovf <= 1'b0;
      end
    end
  end

  // NOTE: the entry storage has no reset; an entry is only readable once the
  // count covers it, so stale contents never reach the bus.
  always_ff @(posedge iPCLK) begin
    if (wr_en) mem[wr_ptr] <= {lap_addr, 2'b00, lap};
  end

`ifdef LAP_IRQ_EN
  always_ff @(posedge iPCLK) begin
    if (!iRESETn) begin
      irq_en <= 1'b0;
      oIRQ   <= 1'b0;
    end else begin
      if (commit && iPWRITE && word == WA_CTRL) irq_en <= iPWDATA[2];
      oIRQ <= irq_en & (~empty | ovf);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_lap_fifo_apb.sv
module tb_lap_fifo_apb;

  localparam int DEPTH = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lap_wr;
  logic [25:0] lap;
  logic [3:0]  lap_addr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
`ifdef LAP_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  lap_fifo_apb #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .iPCLK    (clk),
    .iRESETn  (rst_n),
    .lap_wr   (lap_wr),
    .lap      (lap),
    .lap_addr (lap_addr),
    .iPSEL    (psel),
    .iPENABLE (penable),
    .iPWRITE  (pwrite),
    .iPADDR   (paddr),
    .iPWDATA  (pwdata),
    .oPRDATA  (prdata),
    .oPREADY  (pready)
`ifdef LAP_IRQ_EN
    ,
    .oIRQ     (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of entries, oldest first.
  logic [31:0] model_q[$];
  logic        model_ovf    = 1'b0;
  logic        model_irq_en = 1'b0;
  // Scoreboard of expected read data.
  logic [31:0] exp_q[$];

  function automatic logic [31:0] entry(input logic [25:0] l, input logic [3:0] a);
    return {a, 2'b00, l};
  endfunction

  function automatic logic [31:0] model_status();
    int n = model_q.size();
    return {24'h0, model_irq_en, model_ovf, (n == DEPTH), (n == 0), 4'(n)};
  endfunction

  function automatic void model_push(input logic [31:0] w);
    model_q.push_back(w);
    if (model_q.size() > DEPTH) begin
      void'(model_q.pop_front());
      model_ovf = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_pop();
    if (model_q.size() == 0) return 32'h0;
    return model_q.pop_front();
  endfunction

  // Expected read data for an address; POP also updates the model.
  function automatic logic [31:0] model_read(input logic [7:0] a);
    int wa = int'(a) >> 2;
    int i;
    if (wa == 0) return model_status();
    if (wa == 2) return model_pop();
    if (wa >= 16 && wa < 16 + DEPTH) begin
      i = wa - 16;
      return (i < model_q.size()) ? model_q[i] : 32'h0;
    end
    return 32'h0;
  endfunction

  task automatic lap_pulse(input logic [31:0] w);
    lap_wr = 1'b1; lap = w[25:0]; lap_addr = w[31:28];
    @(posedge clk); #1;
    lap_wr = 1'b0;
  endtask

  // One APB transfer; optionally pulses lap_wr during the oPREADY cycle so it
  // coincides with the commit edge. The wait for oPREADY is bounded.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic lap_at_commit, input logic [31:0] lap_word,
                          output logic [31:0] rdata);
    int waits = 0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    while (pready !== 1'b1 && waits < 8) begin
      @(posedge clk); #1;
      waits++;
    end
    if (pready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL apb_timeout addr=%h: oPREADY=%b after %0d cycles, required 1", addr, pready, waits);
    end
    rdata = prdata;
    if (lap_at_commit) begin
      lap_wr = 1'b1; lap = lap_word[25:0]; lap_addr = lap_word[31:28];
    end
    @(posedge clk); #1;
    lap_wr = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (pready !== 1'b0 || prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: pready=%b prdata=%h, required 0 / 0", pready, prdata);
    end
    // Step a STATUS read by hand to check the single wait state.
    exp_q.push_back(model_status());
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    @(posedge clk); #1;
    penable = 1'b1;
    checks++;
    if (pready !== 1'b0) begin
      errors++; $display("FAIL ready_first_access: pready=%b, required 0", pready);
    end
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    checks++;
    if (pready !== 1'b1) begin
      errors++; $display("FAIL ready_second_access: pready=%b, required 1", pready);
    end
    checks++;
    if (prdata !== exp || prdata !== 32'h0000_0010) begin
      errors++; $display("FAIL reset_status: got %h, required %h", prdata, exp);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pready !== 1'b0 || prdata !== 32'h0) begin
      errors++;
      $display("FAIL ready_release: pready=%b prdata=%h, required 0 / 0", pready, prdata);
    end
  endtask

  task automatic test_fill3();
    logic [7:0]  addrs [8] = '{8'h00, 8'h44, 8'h4C, 8'h0C, 8'h08, 8'h08, 8'h08, 8'h00};
    logic [25:0] laps  [3] = '{26'h64, 26'hC8, 26'h12C};
    logic [31:0] got, exp;
    for (int k = 0; k < 3; k++) begin
      model_push(entry(laps[k], 4'(k + 1)));
      lap_pulse(entry(laps[k], 4'(k + 1)));
    end
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(model_read(addrs[k]));
      apb_xfer(1'b0, addrs[k], 32'h0, 1'b0, 32'h0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL fill3_read[%0d] addr=%h: got %h, required %h", k, addrs[k], got, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  addrs [3] = '{8'h00, 8'h08, 8'h00};
    logic [31:0] got, exp;
    for (int k = 1; k <= 11; k++) begin
      model_push(entry(26'(k), 4'(k)));
      lap_pulse(entry(26'(k), 4'(k)));
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(model_read(addrs[k]));
      apb_xfer(1'b0, addrs[k], 32'h0, 1'b0, 32'h0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL overflow_read[%0d] addr=%h: got %h, required %h", k, addrs[k], got, exp);
      end
    end
    apb_xfer(1'b1, 8'h04, 32'h2, 1'b0, 32'h0, got);
    model_ovf = 1'b0;
    exp_q.push_back(model_read(8'h00));
    apb_xfer(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL ovf_clr_status: got %h, required %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [3] = '{8'h00, 8'h64, 8'h40};
    logic [31:0] got, exp;
    model_push(entry(26'd12, 4'd12));
    lap_pulse(entry(26'd12, 4'd12));
    // POP with a lap landing on the commit edge while full.
    exp_q.push_back(model_pop());
    apb_xfer(1'b0, 8'h08, 32'h0, 1'b1, entry(26'd13, 4'd13), got);
    model_push(entry(26'd13, 4'd13));
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL b2b_pop: got %h, required %h", got, exp);
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(model_read(addrs[k]));
      apb_xfer(1'b0, addrs[k], 32'h0, 1'b0, 32'h0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_read[%0d] addr=%h: got %h, required %h", k, addrs[k], got, exp);
      end
    end
  endtask

  task automatic test_clear();
    logic [7:0]  addrs [4] = '{8'h00, 8'h08, 8'h00, 8'h08};
    logic [31:0] got, exp;
    // CLEAR coincident with a lap: the lap is dropped.
    apb_xfer(1'b1, 8'h04, 32'h1, 1'b1, entry(26'd14, 4'd14), got);
    model_q.delete();
    model_ovf = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(model_read(addrs[k]));
      apb_xfer(1'b0, addrs[k], 32'h0, 1'b0, 32'h0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL clear_read[%0d] addr=%h: got %h, required %h", k, addrs[k], got, exp);
      end
    end
    // POP on empty with a coincident lap: returns 0, lap lands.
    exp_q.push_back(model_pop());
    apb_xfer(1'b0, 8'h08, 32'h0, 1'b1, entry(26'd15, 4'd15), got);
    model_push(entry(26'd15, 4'd15));
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL empty_pop_lap: got %h, required %h", got, exp);
    end
    for (int k = 2; k < 4; k++) begin
      exp_q.push_back(model_read(addrs[k]));
      apb_xfer(1'b0, addrs[k], 32'h0, 1'b0, 32'h0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL clear_read[%0d] addr=%h: got %h, required %h", k, addrs[k], got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    model_push(entry(26'd16, 4'd1));
    lap_pulse(entry(26'd16, 4'd1));
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
    @(posedge clk); #1;
    penable = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ready: pready=%b, required 0", pready);
    end
    psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    model_q.delete();
    model_ovf = 1'b0;
    model_irq_en = 1'b0;
    exp_q.push_back(model_read(8'h00));
    apb_xfer(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_mid_status: got %h, required %h", got, exp);
    end
  endtask

  task automatic test_irq();
    logic [31:0] got, exp;
    apb_xfer(1'b1, 8'h04, 32'h4, 1'b0, 32'h0, got);
`ifdef LAP_IRQ_EN
    model_irq_en = 1'b1;
`endif
    exp_q.push_back(model_read(8'h00));
    apb_xfer(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL irq_en_status: got %h, required %h", got, exp);
    end
`ifdef LAP_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_idle: irq=%b, required 0", irq);
    end
    model_push(entry(26'd17, 4'd2));
    lap_pulse(entry(26'd17, 4'd2));
    for (int k = 0; k < 2 && irq !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_raise: irq=%b, required 1", irq);
    end
    exp_q.push_back(model_pop());
    apb_xfer(1'b0, 8'h08, 32'h0, 1'b0, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL irq_pop: got %h, required %h", got, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_drop: irq=%b, required 0", irq);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; lap_wr = 1'b0; lap = '0; lap_addr = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    test_reset();
    test_fill3();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
